// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared encodings, FSM states and lane helpers for the data memory
package mem_pkg;

   localparam logic [1:0] BHW_BYTE = 2'b00;
   localparam logic [1:0] BHW_HALF = 2'b01;
   localparam logic [1:0] BHW_WORD = 2'b11;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } state_t;

   function automatic logic [3:0] byte_en(input logic [1:0] bhw, input logic [1:0] off);
      logic [3:0] be;
      be = 4'b0000;
      case (bhw)
         BHW_BYTE: be = 4'b0001 << off;
         BHW_HALF: be = off[1] ? 4'b1100 : 4'b0011;
         BHW_WORD: be = 4'b1111;
         default:  be = 4'b0000;
      endcase
      return be;
   endfunction

   // Replicate sub-word store data so every enabled lane sees the right bytes.
   function automatic logic [31:0] store_lanes(input logic [1:0] bhw, input logic [31:0] data);
      logic [31:0] lanes;
      case (bhw)
         BHW_BYTE: lanes = {4{data[7:0]}};
         BHW_HALF: lanes = {2{data[15:0]}};
         default:  lanes = data;
      endcase
      return lanes;
   endfunction

   function automatic logic [31:0] load_ext(input logic [31:0] word, input logic [1:0] bhw,
                                            input logic [1:0] off, input logic uns);
      logic [31:0] sh;
      logic [31:0] res;
      sh = word >> {off, 3'b000};
      case (bhw)
         BHW_BYTE: res = uns ? {24'h000000, sh[7:0]}  : {{24{sh[7]}}, sh[7:0]};
         BHW_HALF: res = uns ? {16'h0000, sh[15:0]}   : {{16{sh[15]}}, sh[15:0]};
         default:  res = word;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/bram_be.sv
// rtl/bram_be.sv - word RAM with byte-enable write port and two synchronous read ports
module bram_be #(
   parameter int AW = 8
) (
   input  logic          i_clk,
   input  logic          i_reset,
   input  logic          i_we,
   input  logic [3:0]    i_be,
   input  logic [AW-1:0] i_addr,
   input  logic [31:0]   i_wdata,
   input  logic          i_re,
   output logic [31:0]   o_rdata,
   input  logic [AW-1:0] i_dbg_addr,
   output logic [31:0]   o_dbg_data
);

   logic [31:0] r_mem [0:(2**AW)-1];
   logic [31:0] r_rdata;
   logic [31:0] r_dbg_data;

   // Array has no reset so it maps onto block RAM; only the read registers reset.
   always_ff @(posedge i_clk) begin
      if (i_we) begin
         for (int k = 0; k < 4; k++) begin
            if (i_be[k]) begin
               r_mem[i_addr][8*k +: 8] <= i_wdata[8*k +: 8];
            end
         end
      end
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_rdata    <= 32'h0;
         r_dbg_data <= 32'h0;
      end else begin
         if (i_re) begin
            r_rdata <= r_mem[i_addr];
         end
         r_dbg_data <= r_mem[i_dbg_addr];
      end
   end

   assign o_rdata    = r_rdata;
   assign o_dbg_data = r_dbg_data;

endmodule

// File: rtl/data_mem_ws.sv
// rtl/data_mem_ws.sv - MEM-stage data memory with wait states, alignment faults and debug port
module data_mem_ws
   import mem_pkg::*;
#(
   parameter int W    = 10,
   parameter int WAIT = 0
) (
   input  logic         i_clk,
   input  logic         i_reset,
   input  logic         i_mem_read,
   input  logic         i_mem_write,
   input  logic [1:0]   i_bhw,
   input  logic         i_unsigned,
   input  logic [W-1:0] i_addr,
   input  logic [31:0]  i_data,
   input  logic [W-3:0] i_debug_addr,
   output logic [31:0]  o_data,
   output logic         o_rd_valid,
   output logic         o_stall,
   output logic         o_fault,
   output logic [31:0]  o_debug_mem
);

   localparam bit         C_HAS_WAIT = (WAIT > 0);
   localparam logic [3:0] C_CNT_LOAD = (WAIT > 0) ? 4'(WAIT - 1) : 4'd0;

   state_t      r_state;
   state_t      w_state_nxt;
   logic [3:0]  r_cnt;
   logic [3:0]  w_cnt_nxt;
   logic        r_rd_valid;
   logic        r_fault;
   logic [1:0]  r_ld_bhw;
   logic [1:0]  r_ld_off;
   logic        r_ld_uns;

   logic        w_any;
   logic        w_misalign;
   logic        w_illegal;
   logic        w_legal;
   logic        w_done;
   logic        w_stall;
   logic        w_commit;
   logic        w_we;
   logic        w_re;
   logic [3:0]  w_be;
   logic [31:0] w_wdata;
   logic [31:0] w_rdata;

   assign w_any      = i_mem_read | i_mem_write;
   assign w_misalign = ((i_bhw == BHW_HALF) && i_addr[0]) ||
                       ((i_bhw == BHW_WORD) && (i_addr[1:0] != 2'b00));
   assign w_illegal  = w_any && ((i_mem_read && i_mem_write) || (i_bhw == 2'b10) || w_misalign);
   assign w_legal    = w_any && !w_illegal;

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_done      = 1'b0;
      w_stall     = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_legal) begin
               if (C_HAS_WAIT) begin
                  w_state_nxt = ST_BUSY;
                  w_cnt_nxt   = C_CNT_LOAD;
                  w_stall     = 1'b1;
               end else begin
                  w_done = 1'b1;
               end
            end
         end
         ST_BUSY: begin
            // A dropped (or corrupted) request while waiting is a pipeline flush.
            if (!w_legal) begin
               w_state_nxt = ST_IDLE;
               w_cnt_nxt   = 4'd0;
            end else if (r_cnt != 4'd0) begin
               w_cnt_nxt = r_cnt - 4'd1;
               w_stall   = 1'b1;
            end else begin
               w_state_nxt = ST_IDLE;
               w_done      = 1'b1;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = 4'd0;
         end
      endcase
   end

   assign o_stall  = w_stall & ~i_reset;
   assign w_commit = w_done & ~i_reset;
   assign w_we     = w_commit & i_mem_write;
   assign w_re     = w_commit & i_mem_read;
   assign w_be     = byte_en(i_bhw, i_addr[1:0]);
   assign w_wdata  = store_lanes(i_bhw, i_data);

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_state    <= ST_IDLE;
         r_cnt      <= 4'd0;
         r_rd_valid <= 1'b0;
         r_fault    <= 1'b0;
         r_ld_bhw   <= BHW_WORD;
         r_ld_off   <= 2'b00;
         r_ld_uns   <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_cnt      <= w_cnt_nxt;
         r_rd_valid <= w_re;
         r_fault    <= w_illegal;
         if (w_re) begin
            r_ld_bhw <= i_bhw;
            r_ld_off <= i_addr[1:0];
            r_ld_uns <= i_unsigned;
         end
      end
   end

   bram_be #(
      .AW (W - 2)
   ) u_bram (
      .i_clk      (i_clk),
      .i_reset    (i_reset),
      .i_we       (w_we),
      .i_be       (w_be),
      .i_addr     (i_addr[W-1:2]),
      .i_wdata    (w_wdata),
      .i_re       (w_re),
      .o_rdata    (w_rdata),
      .i_dbg_addr (i_debug_addr),
      .o_dbg_data (o_debug_mem)
   );

   // Lane select/extend is applied to the registered RAM word using the registered access shape.
   assign o_data     = load_ext(w_rdata, r_ld_bhw, r_ld_off, r_ld_uns);
   assign o_rd_valid = r_rd_valid;
   assign o_fault    = r_fault;

endmodule

// File: tb/tb_data_mem_ws.sv
// tb/tb_data_mem_ws.sv - directed scoreboard bench for data_mem_ws with WAIT=0 and WAIT=3
module tb_data_mem_ws;
   import mem_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        rd, wr, uns;
   logic [1:0]  bhw;
   logic [9:0]  addr;
   logic [31:0] wdat;
   logic [7:0]  dbg;
   logic        use3;

   logic [31:0] d0_data, d0_debug, d3_data, d3_debug;
   logic        d0_rdv, d0_stall, d0_fault, d3_rdv, d3_stall, d3_fault;
   logic [31:0] m_data, m_debug;
   logic        m_rdv, m_stall, m_fault;

   int          checks = 0;
   int          errors = 0;
   logic [31:0] sb [$];
   logic [31:0] last_load;
   logic [7:0]  mdl [0:1023];
   int          nv;

   always #5 clk = ~clk;

   data_mem_ws #(.W(10), .WAIT(0)) u_dut0 (
      .i_clk(clk), .i_reset(rst), .i_mem_read(rd), .i_mem_write(wr), .i_bhw(bhw),
      .i_unsigned(uns), .i_addr(addr), .i_data(wdat), .i_debug_addr(dbg),
      .o_data(d0_data), .o_rd_valid(d0_rdv), .o_stall(d0_stall), .o_fault(d0_fault),
      .o_debug_mem(d0_debug));

   data_mem_ws #(.W(10), .WAIT(3)) u_dut3 (
      .i_clk(clk), .i_reset(rst), .i_mem_read(rd), .i_mem_write(wr), .i_bhw(bhw),
      .i_unsigned(uns), .i_addr(addr), .i_data(wdat), .i_debug_addr(dbg),
      .o_data(d3_data), .o_rd_valid(d3_rdv), .o_stall(d3_stall), .o_fault(d3_fault),
      .o_debug_mem(d3_debug));

   assign m_data  = use3 ? d3_data  : d0_data;
   assign m_debug = use3 ? d3_debug : d0_debug;
   assign m_rdv   = use3 ? d3_rdv   : d0_rdv;
   assign m_stall = use3 ? d3_stall : d0_stall;
   assign m_fault = use3 ? d3_fault : d0_fault;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic void mdl_store(input logic [1:0] b, input logic [9:0] a_i, input logic [31:0] d);
      int a;
      a = int'(a_i);
      mdl[a] = d[7:0];
      if (b != BHW_BYTE) mdl[a+1] = d[15:8];
      if (b == BHW_WORD) begin
         mdl[a+2] = d[23:16];
         mdl[a+3] = d[31:24];
      end
   endfunction

   function automatic logic [31:0] mdl_load(input logic [1:0] b, input logic u, input logic [9:0] a_i);
      int a;
      a = int'(a_i);
      if (b == BHW_BYTE) return u ? {24'h0, mdl[a]} : {{24{mdl[a][7]}}, mdl[a]};
      if (b == BHW_HALF) return u ? {16'h0, mdl[a+1], mdl[a]} : {{16{mdl[a+1][7]}}, mdl[a+1], mdl[a]};
      return {mdl[a+3], mdl[a+2], mdl[a+1], mdl[a]};
   endfunction

   task automatic req(input logic rd_i, input logic wr_i, input logic [1:0] b_i, input logic u_i,
                      input logic [9:0] a_i, input logic [31:0] d_i, input int exp_stall, input string tag);
      int n;
      logic [31:0] e;
      n = 0;
      rd = rd_i; wr = wr_i; bhw = b_i; uns = u_i; addr = a_i; wdat = d_i;
      if (rd_i) sb.push_back(mdl_load(b_i, u_i, a_i));
      #1;
      while (m_stall === 1'b1 && n < 20) begin
         n++;
         @(negedge clk);
      end
      chk({tag, "_stall_cycles"}, 32'(n), 32'(exp_stall));
      @(posedge clk); #1;
      rd = 1'b0; wr = 1'b0;
      chk({tag, "_rd_valid"}, 32'(m_rdv), 32'(rd_i));
      if (m_rdv === 1'b1) begin
         if (sb.size() > 0) begin
            e = sb.pop_front();
            chk({tag, "_data"}, m_data, e);
            last_load = e;
         end else begin
            chk({tag, "_sb_pending"}, 32'(sb.size()), 32'd1);
         end
      end
      if (wr_i) mdl_store(b_i, a_i, d_i);
      @(negedge clk);
   endtask

   task automatic fault(input logic rd_i, input logic wr_i, input logic [1:0] b_i,
                        input logic [9:0] a_i, input string tag);
      rd = rd_i; wr = wr_i; bhw = b_i; uns = 1'b0; addr = a_i; wdat = 32'h0;
      #1;
      chk({tag, "_stall"}, 32'(m_stall), 32'd0);
      @(posedge clk); #1;
      rd = 1'b0; wr = 1'b0;
      chk({tag, "_fault"}, 32'(m_fault), 32'd1);
      chk({tag, "_rd_valid"}, 32'(m_rdv), 32'd0);
      chk({tag, "_data_held"}, m_data, last_load);
      @(posedge clk); #1;
      chk({tag, "_fault_pulse"}, 32'(m_fault), 32'd0);
      @(negedge clk);
   endtask

   initial begin
      use3 = 1'b0; last_load = 32'h0;
      rst = 1'b1; rd = 1'b1; wr = 1'b0; bhw = BHW_WORD; uns = 1'b0; addr = 10'h010;
      wdat = 32'h0; dbg = 8'h00;

      // reset state, with a legal load held on the inputs
      @(negedge clk); #1;
      chk("rst_d0_data", d0_data, 32'h0);
      chk("rst_d0_rdv", 32'(d0_rdv), 32'd0);
      chk("rst_d0_fault", 32'(d0_fault), 32'd0);
      chk("rst_d0_debug", d0_debug, 32'h0);
      chk("rst_d3_stall", 32'(d3_stall), 32'd0);
      chk("rst_d3_data", d3_data, 32'h0);
      rd = 1'b0;
      @(negedge clk); rst = 1'b0;
      @(negedge clk);

      // WAIT=0 functional sequence
      req(0, 1, BHW_WORD, 0, 10'h010, 32'h11223344, 0, "w0_st_word");
      req(1, 0, BHW_WORD, 0, 10'h010, 32'h0, 0, "w0_ld_word");
      req(0, 1, BHW_WORD, 0, 10'h020, 32'h00000000, 0, "w0_clr");
      req(0, 1, BHW_BYTE, 0, 10'h021, 32'hAAAAAA80, 0, "w0_st_b80");
      req(0, 1, BHW_BYTE, 0, 10'h022, 32'h5555557F, 0, "w0_st_b7f");
      req(1, 0, BHW_BYTE, 0, 10'h021, 32'h0, 0, "w0_ld_sb");
      req(1, 0, BHW_BYTE, 1, 10'h021, 32'h0, 0, "w0_ld_ub");
      req(1, 0, BHW_HALF, 0, 10'h022, 32'h0, 0, "w0_ld_h");
      req(1, 0, BHW_WORD, 0, 10'h020, 32'h0, 0, "w0_ld_w20");
      req(0, 1, BHW_HALF, 0, 10'h026, 32'h1234BEEF, 0, "w0_st_half");
      req(1, 0, BHW_HALF, 0, 10'h026, 32'h0, 0, "w0_ld_sh");
      req(1, 0, BHW_HALF, 1, 10'h026, 32'h0, 0, "w0_ld_uh");
      req(1, 0, BHW_WORD, 0, 10'h024, 32'h0, 0, "w0_ld_w24");

      // illegal requests leave memory and o_data alone
      req(0, 1, BHW_WORD, 0, 10'h000, 32'hA5A5A5A5, 0, "w0_st_w0");
      fault(0, 1, BHW_WORD, 10'h002, "flt_word");
      fault(0, 1, BHW_HALF, 10'h003, "flt_half");
      fault(0, 1, 2'b10, 10'h000, "flt_bhw10");
      fault(1, 1, BHW_WORD, 10'h000, "flt_rdwr");
      dbg = 8'h00;
      @(negedge clk); @(negedge clk);
      chk("flt_mem_intact", m_debug, mdl_load(BHW_WORD, 0, 10'h000));

      // debug port observes a store while the pipeline loads elsewhere
      dbg = 8'h10;
      req(0, 1, BHW_WORD, 0, 10'h040, 32'hDEADBEEF, 0, "dbg_st");
      req(1, 0, BHW_WORD, 0, 10'h010, 32'h0, 0, "dbg_ld_other");
      chk("dbg_word", m_debug, 32'hDEADBEEF);

      // WAIT=3 instance
      use3 = 1'b1;
      rst = 1'b1; @(negedge clk); rst = 1'b0; @(negedge clk);
      last_load = 32'h0;
      req(0, 1, BHW_WORD, 0, 10'h030, 32'h01020304, 3, "w3_st");
      req(1, 0, BHW_WORD, 0, 10'h030, 32'h0, 3, "w3_ld");
      req(1, 0, BHW_BYTE, 0, 10'h033, 32'h0, 3, "w3_ld_b");

      // load flushed after its first cycle
      rd = 1'b1; bhw = BHW_WORD; uns = 1'b0; addr = 10'h030;
      #1; chk("fl_ld_stall", 32'(m_stall), 32'd1);
      @(negedge clk); rd = 1'b0;
      nv = 0;
      repeat (6) begin
         @(posedge clk); #1;
         if (m_rdv === 1'b1) nv++;
      end
      chk("fl_ld_no_rdv", 32'(nv), 32'd0);
      chk("fl_ld_stall_low", 32'(m_stall), 32'd0);
      @(negedge clk);

      // store flushed in its third cycle
      wr = 1'b1; bhw = BHW_WORD; addr = 10'h030; wdat = 32'h55667788;
      @(negedge clk); @(negedge clk);
      wr = 1'b0; dbg = 8'h0C;
      repeat (6) @(negedge clk);
      chk("fl_st_no_write", m_debug, mdl_load(BHW_WORD, 0, 10'h030));

      // reset in the middle of a waiting store
      wr = 1'b1; bhw = BHW_WORD; addr = 10'h030; wdat = 32'hCAFEF00D;
      @(negedge clk);
      chk("rb_busy_stall", 32'(m_stall), 32'd1);
      rst = 1'b1; #1;
      chk("rb_data", d3_data, 32'h0);
      chk("rb_rdv", 32'(d3_rdv), 32'd0);
      chk("rb_fault", 32'(d3_fault), 32'd0);
      chk("rb_stall", 32'(d3_stall), 32'd0);
      chk("rb_debug", d3_debug, 32'h0);
      @(negedge clk); rst = 1'b0; wr = 1'b0;
      repeat (3) @(negedge clk);
      chk("rb_no_partial", m_debug, mdl_load(BHW_WORD, 0, 10'h030));
      req(1, 0, BHW_WORD, 0, 10'h030, 32'h0, 3, "rb_next_ld");

      chk("sb_drained", 32'(sb.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/data_mem_ws.md
# data_mem_ws

Parametrised MEM-stage data memory for the pipeline: byte-addressed, little-endian, 2^W bytes organised as 32-bit words, with byte/half/word stores, signed and unsigned sub-word loads, and alignment-fault detection. A configurable wait-state engine holds the pipeline through a stall output to model slow memory. An independent registered debug read port serves the debug unit without disturbing pipeline accesses.

## Interface
- W, default 10, byte-address width; capacity 2^W bytes = 2^(W-2) words (W ≥ 3)
- WAIT, default 0, wait states per access (0..15); 0 gives single-cycle access
- i_clk  in  1  clock, all state on rising edge
- i_reset  in  1  asynchronous, active-high reset
- i_mem_read  in  1  load request
- i_mem_write  in  1  store request
- i_bhw  in  2  access size: 00 byte, 01 half, 11 word, 10 reserved
- i_unsigned  in  1  loads: 1 zero-extends, 0 sign-extends sub-word data
- i_addr  in  W  byte address
- i_data  in  32  store data; byte and half stores use the low 8/16 bits
- i_debug_addr  in  W-2  debug word index
- o_data  out  32  load result, registered
- o_rd_valid  out  1  one-cycle pulse when o_data updated
- o_stall  out  1  pipeline hold request, combinational
- o_fault  out  1  one-cycle pulse on a misaligned or illegal request
- o_debug_mem  out  32  word at i_debug_addr, registered

## Operation
- Request = exactly one of i_mem_read / i_mem_write high. Both high is illegal.
- Illegal request:
  - i_bhw = 10;
  - both read and write high;
  - half access with addr[0] = 1;
  - word access with addr[1:0] ≠ 0.
- Illegal request handling: no memory access, no stall. o_fault = 1 on the next cycle. o_data is unchanged.
- FSM has two states, IDLE and BUSY, with a 4-bit counter cnt.
  - IDLE, legal request, WAIT = 0: access completes at this edge; stay IDLE.
  - IDLE, legal request, WAIT > 0: go to BUSY with cnt = WAIT-1.
  - BUSY, cnt > 0: decrement cnt.
  - BUSY, cnt = 0: complete the access; go to IDLE.
  - BUSY, request dropped (flush): return to IDLE with no access, no o_rd_valid.
- o_stall = (IDLE and legal request and WAIT > 0) or (BUSY and request held). The completing cycle has o_stall = 0.
- Pipeline holds i_addr, i_bhw, i_data and i_unsigned stable while o_stall = 1. The block latches nothing and uses the live inputs at completion.
- Store: byte enables are derived from the size and addr[1:0]. Lane k occupies bits 8k+7:8k.
  - Byte store writes i_data[7:0] into lane addr[1:0].
  - Half store writes i_data[15:0] into lanes addr[1]*2 and +1.
  - Word store writes all four lanes.
  - Other bytes are untouched.
- Load: selects the byte/half by address, extends per i_unsigned, and registers the result into o_data with o_rd_valid = 1.
  - Example: byte 0x80 loads as 0xFFFFFF80 signed, 0x00000080 unsigned.
- Debug port: o_debug_mem <= mem[i_debug_addr] on every edge, independent of the FSM. A store committed at edge n is visible on o_debug_mem after edge n+1.
- Memory contents are not cleared by reset and have no defined initial value.

## Timing
- Reset values: state IDLE, cnt 0, o_data 0, o_rd_valid 0, o_fault 0, o_debug_mem 0. o_stall evaluates to 0 while i_reset is high.
- Access latency is WAIT+1 cycles from the first cycle the request is visible. o_stall is high for the first WAIT cycles.
- The write commits, or o_data/o_rd_valid update, at the edge ending cycle WAIT+1.
- Back-to-back requests: a new request is accepted in the cycle after completion, so sustained throughput is one access per WAIT+1 cycles.
- Reset asserted mid-BUSY: the access is abandoned with no partial write, and all outputs return to their reset values.
- A load from an address stored on the previous completion returns the new data, because the write commits before the next read edge.
- Address wrap: only the W address bits exist, so there is no wrap logic.

## Structure
- Package mem_pkg holds:
  - bhw encodings BHW_BYTE / BHW_HALF / BHW_WORD;
  - the FSM state enum;
  - the byte-enable and load-extend functions.
- Sub-module bram_be: 2^(W-2) × 32 RAM with a 4-bit byte-enable write port and two synchronous read ports (pipeline and debug).
- Alignment check, FSM, counter and lane muxing live in data_mem_ws.

## Test plan
- WAIT=0: word store 0x11223344 at 0x010, then word load at 0x010 → o_data = 0x11223344 one cycle later, o_stall never high.
- Byte stores 0x80 at 0x021 and 0x7F at 0x022, then:
  - signed byte load at 0x021 → 0xFFFFFF80;
  - unsigned byte load at 0x021 → 0x00000080;
  - half load at 0x022 → 0x0000007F.
- WAIT=3: load request held → o_stall high for exactly 3 cycles, o_rd_valid on the 4th edge. Dropping the request in cycle 2 → no o_rd_valid, no write.
- Misalignment: word at 0x002, half at 0x003, bhw=10, and read+write together → each gives an o_fault pulse, memory unchanged (verified via the debug port), o_stall 0.
- Debug port: word store 0xDEADBEEF at 0x040 → o_debug_mem = 0xDEADBEEF with i_debug_addr = 0x10 after one edge, concurrent with a pipeline load elsewhere.
- Reset asserted during BUSY of a store → target word unchanged, all outputs 0, next request accepted normally.
